// File: rtl/csr_file_if.sv
`default_nettype none
// ============================================================================
// Module      : csr_file_if
// Description : CSR write channel from writeback plus the execute read port.
// Revision    : 1.0 - initial release
// ============================================================================
interface csr_file_if;
    logic        csr_wr_en_i;
    logic [11:0] csr_addr_i;
    logic [31:0] csr_data_i;
    logic [11:0] csr_rd_addr_i;
    logic [31:0] csr_rd_data_o;
    logic        csr_rd_illegal_o;

    // Pipeline side (writeback + execute)
    modport master (
        output csr_wr_en_i, csr_addr_i, csr_data_i, csr_rd_addr_i,
        input  csr_rd_data_o, csr_rd_illegal_o
    );

    // Register file side
    modport slave (
        input  csr_wr_en_i, csr_addr_i, csr_data_i, csr_rd_addr_i,
        output csr_rd_data_o, csr_rd_illegal_o
    );
endinterface
`default_nettype wire

// File: rtl/csr_file.sv
`default_nettype none
// ============================================================================
// Module      : csr_file
// Description : Machine-mode CSR file for rv32i: read port, trap/mret update,
//               64-bit cycle/instret counters. Optional mcountinhibit at 0x320
//               enabled by defining CSR_COUNTER_INHIBIT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module csr_file #(
    parameter logic [31:0] HART_ID     = 32'h0,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
    input  wire logic        clk_i,
    input  wire logic        rst_i,
    csr_file_if.slave        csr_bus,
    input  wire logic        instr_retire_i,
    input  wire logic        trap_i,
    input  wire logic [31:0] trap_pc_i,
    input  wire logic [31:0] trap_cause_i,
    input  wire logic [31:0] trap_val_i,
    input  wire logic        mret_i,
    output logic      [31:0] mtvec_o,
    output logic      [31:0] mepc_o,
    output logic             mstatus_mie_o
);

    localparam logic [11:0] c_mstatus   = 12'h300;
    localparam logic [11:0] c_misa      = 12'h301;
    localparam logic [11:0] c_mie       = 12'h304;
    localparam logic [11:0] c_mtvec     = 12'h305;
    localparam logic [11:0] c_mcntinh   = 12'h320;
    localparam logic [11:0] c_mscratch  = 12'h340;
    localparam logic [11:0] c_mepc      = 12'h341;
    localparam logic [11:0] c_mcause    = 12'h342;
    localparam logic [11:0] c_mtval     = 12'h343;
    localparam logic [11:0] c_mip       = 12'h344;
    localparam logic [11:0] c_mcycle    = 12'hB00;
    localparam logic [11:0] c_mcycleh   = 12'hB80;
    localparam logic [11:0] c_minstret  = 12'hB02;
    localparam logic [11:0] c_minstreth = 12'hB82;
    localparam logic [11:0] c_cycle     = 12'hC00;
    localparam logic [11:0] c_cycleh    = 12'hC80;
    localparam logic [11:0] c_instret   = 12'hC02;
    localparam logic [11:0] c_instreth  = 12'hC82;
    localparam logic [11:0] c_mhartid   = 12'hF14;

    localparam logic [31:0] c_misa_val  = 32'h4000_0100;
    localparam logic [31:0] c_mie_mask  = 32'h0000_0888;
    localparam logic [31:0] c_align     = 32'hFFFF_FFFC;

    logic        r_mie_bit;
    logic        r_mpie;
    logic [31:0] r_mie;
    logic [31:0] r_mtvec;
    logic [31:0] r_mscratch;
    logic [31:0] r_mepc;
    logic [31:0] r_mcause;
    logic [31:0] r_mtval;
    logic [63:0] r_mcycle;
    logic [63:0] r_minstret;

    logic        w_we;
    logic        w_trap_lock;
    logic        w_inh_cy;
    logic        w_inh_ir;
    logic [31:0] w_mcntinh_rd;

    // Addresses with [11:10]==2'b11 are read-only by encoding.
    assign w_we        = csr_bus.csr_wr_en_i && (csr_bus.csr_addr_i[11:10] != 2'b11);
    // Trap or mret owns mstatus/mepc/mcause/mtval this cycle.
    assign w_trap_lock = trap_i || mret_i;

`ifdef CSR_COUNTER_INHIBIT_EN
    logic r_inh_cy;
    logic r_inh_ir;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_inh_cy <= 1'b0;
            r_inh_ir <= 1'b0;
        end else if (w_we && csr_bus.csr_addr_i == c_mcntinh) begin
            r_inh_cy <= csr_bus.csr_data_i[0];
            r_inh_ir <= csr_bus.csr_data_i[2];
        end
    end

    assign w_inh_cy     = r_inh_cy;
    assign w_inh_ir     = r_inh_ir;
    assign w_mcntinh_rd = {29'd0, r_inh_ir, 1'b0, r_inh_cy};
`else
    assign w_inh_cy     = 1'b0;
    assign w_inh_ir     = 1'b0;
    assign w_mcntinh_rd = 32'd0;
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_mie_bit <= 1'b0;
            r_mpie    <= 1'b0;
            r_mepc    <= 32'd0;
            r_mcause  <= 32'd0;
            r_mtval   <= 32'd0;
        end else if (trap_i) begin
            r_mpie    <= r_mie_bit;
            r_mie_bit <= 1'b0;
            r_mepc    <= trap_pc_i & c_align;
            r_mcause  <= trap_cause_i;
            r_mtval   <= trap_val_i;
        end else if (mret_i) begin
            r_mie_bit <= r_mpie;
            r_mpie    <= 1'b1;
        end else if (w_we && !w_trap_lock) begin
            case (csr_bus.csr_addr_i)
                c_mstatus: begin
                    r_mie_bit <= csr_bus.csr_data_i[3];
                    r_mpie    <= csr_bus.csr_data_i[7];
                end
                c_mepc:   r_mepc   <= csr_bus.csr_data_i & c_align;
                c_mcause: r_mcause <= csr_bus.csr_data_i;
                c_mtval:  r_mtval  <= csr_bus.csr_data_i;
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_mie      <= 32'd0;
            r_mtvec    <= MTVEC_RESET & c_align;
            r_mscratch <= 32'd0;
        end else if (w_we) begin
            case (csr_bus.csr_addr_i)
                c_mie:      r_mie      <= csr_bus.csr_data_i & c_mie_mask;
                c_mtvec:    r_mtvec    <= csr_bus.csr_data_i & c_align;
                c_mscratch: r_mscratch <= csr_bus.csr_data_i;
                default:    ;
            endcase
        end
    end

    // A write to either half replaces the increment; the other half holds.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_mcycle   <= 64'd0;
            r_minstret <= 64'd0;
        end else begin
            if (w_we && csr_bus.csr_addr_i == c_mcycle)
                r_mcycle[31:0]  <= csr_bus.csr_data_i;
            else if (w_we && csr_bus.csr_addr_i == c_mcycleh)
                r_mcycle[63:32] <= csr_bus.csr_data_i;
            else if (!w_inh_cy)
                r_mcycle        <= r_mcycle + 64'd1;

            if (w_we && csr_bus.csr_addr_i == c_minstret)
                r_minstret[31:0]  <= csr_bus.csr_data_i;
            else if (w_we && csr_bus.csr_addr_i == c_minstreth)
                r_minstret[63:32] <= csr_bus.csr_data_i;
            else if (instr_retire_i && !w_inh_ir)
                r_minstret        <= r_minstret + 64'd1;
        end
    end

    always_comb begin
        csr_bus.csr_rd_data_o    = 32'd0;
        csr_bus.csr_rd_illegal_o = 1'b0;
        case (csr_bus.csr_rd_addr_i)
            c_mstatus:              csr_bus.csr_rd_data_o = {19'd0, 2'b11, 3'd0, r_mpie, 3'd0, r_mie_bit, 3'd0};
            c_misa:                 csr_bus.csr_rd_data_o = c_misa_val;
            c_mie:                  csr_bus.csr_rd_data_o = r_mie;
            c_mtvec:                csr_bus.csr_rd_data_o = r_mtvec;
            c_mscratch:             csr_bus.csr_rd_data_o = r_mscratch;
            c_mepc:                 csr_bus.csr_rd_data_o = r_mepc;
            c_mcause:               csr_bus.csr_rd_data_o = r_mcause;
            c_mtval:                csr_bus.csr_rd_data_o = r_mtval;
            c_mip:                  csr_bus.csr_rd_data_o = 32'd0;
            c_mcycle,   c_cycle:    csr_bus.csr_rd_data_o = r_mcycle[31:0];
            c_mcycleh,  c_cycleh:   csr_bus.csr_rd_data_o = r_mcycle[63:32];
            c_minstret, c_instret:  csr_bus.csr_rd_data_o = r_minstret[31:0];
            c_minstreth, c_instreth: csr_bus.csr_rd_data_o = r_minstret[63:32];
            c_mhartid:              csr_bus.csr_rd_data_o = HART_ID;
`ifdef CSR_COUNTER_INHIBIT_EN
            c_mcntinh:              csr_bus.csr_rd_data_o = w_mcntinh_rd;
`endif
            default:                csr_bus.csr_rd_illegal_o = 1'b1;
        endcase
    end

    assign mtvec_o       = r_mtvec;
    assign mepc_o        = r_mepc;
    assign mstatus_mie_o = r_mie_bit;

`ifndef CSR_COUNTER_INHIBIT_EN
    // Keeps the disabled-feature tie-off visibly consumed.
    logic w_unused;
    assign w_unused = |w_mcntinh_rd;
`endif

endmodule
`default_nettype wire
